// File: rtl/cclut_sort_pkg.sv
// rtl/cclut_sort_pkg.sv - shared types and helpers for the pipelined ccLUT CFEB sorter
//
// Contents:
//   DEF_MXPATB / DEF_MXKEYB / DEF_MXPATC : default candidate field widths
//   MAX_CFEB                             : largest supported candidate count
//   clog2()                              : elaboration-time ceiling log2
//   node_t                               : one comparison-tree node {live, pat, key, carry, idx}
package cclut_sort_pkg;

    localparam int DEF_MXPATB = 6;
    localparam int DEF_MXKEYB = 5;
    localparam int DEF_MXPATC = 11;
    localparam int MAX_CFEB   = 16;

    // Ceiling log2; clog2(1) = 0, clog2(7) = 3, clog2(16) = 4.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Node field widths. The index field is sized for the largest build so
    // one node type serves every MXCFEB.
    localparam int NODE_PATB = DEF_MXPATB;
    localparam int NODE_KEYB = DEF_MXKEYB;
    localparam int NODE_PATC = DEF_MXPATC;
    localparam int NODE_IDXB = clog2(MAX_CFEB);

    typedef struct packed {
        logic                 live;
        logic [NODE_PATB-1:0] pat;
        logic [NODE_KEYB-1:0] key;
        logic [NODE_PATC-1:0] carry;
        logic [NODE_IDXB-1:0] idx;
    } node_t;

    localparam int NODE_W = $bits(node_t);

endpackage

// File: rtl/cclut_sort_node.sv
// rtl/cclut_sort_node.sv - registered two-input merge of ccLUT sort-tree nodes
//
// Parameters:
//   SORT_LSB : 0 ignores the pattern lsb (bend direction) in the compare, 1 uses the full pattern
// Ports:
//   clock : system clock
//   reset : synchronous active-high reset, clears the output node
//   a     : lower-index child node
//   b     : higher-index child node
//   q     : registered winner (dead and all-zero when neither child is live)
module cclut_sort_node
    import cclut_sort_pkg::*;
#(
    parameter int SORT_LSB = 0
) (
    input  logic  clock,
    input  logic  reset,
    input  node_t a,
    input  node_t b,
    output node_t q
);

    logic [NODE_PATB-1:0] sort_a;
    logic [NODE_PATB-1:0] sort_b;
    node_t                win;

    always_comb begin
        sort_a = (SORT_LSB != 0) ? a.pat : {1'b0, a.pat[NODE_PATB-1:1]};
        sort_b = (SORT_LSB != 0) ? b.pat : {1'b0, b.pat[NODE_PATB-1:1]};
        win    = '0;
        if (a.live && b.live) begin
            // Strict compare: equal quality keeps the lower-index child.
            win = (sort_b > sort_a) ? b : a;
        end else if (a.live) begin
            win = a;
        end else if (b.live) begin
            win = b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= win;
        end
    end

endmodule

// File: rtl/best_1ofn_busy_cclut_pipe.sv
// rtl/best_1ofn_busy_cclut_pipe.sv - pipelined best-1-of-N ccLUT CFEB sorter with busy masking
//
// Selects the highest-quality non-busy CLCT candidate through a registered
// binary comparison tree; one candidate set per clock, NLVL clocks latency.
//
// Ports:
//   clock      : 80 MHz system clock
//   reset      : synchronous active-high reset
//   in_vld     : candidate set valid this cycle
//   pat        : packed patterns, CFEB i at [i*MXPATB +: MXPATB]
//   key        : packed local 1/2-strip keys
//   carry      : packed ccLUT comparator codes
//   bsy        : per-CFEB busy, 1 removes that candidate from the compare
//   best_vld   : in_vld delayed NLVL clocks
//   best_pat   : winning pattern
//   best_key   : {cfeb index, local key} of the winner
//   best_carry : winning ccLUT code
//   best_cfeb  : winning CFEB index
//   best_bsy   : every candidate of a valid set was busy
module best_1ofn_busy_cclut_pipe
    import cclut_sort_pkg::*;
#(
    parameter int MXCFEB   = 7,
    parameter int MXPATB   = DEF_MXPATB,
    parameter int MXKEYB   = DEF_MXKEYB,
    parameter int MXPATC   = DEF_MXPATC,
    parameter int SORT_LSB = 0,
    parameter int MXCFEBB  = clog2(MXCFEB),
    parameter int MXKEYBX  = MXKEYB + MXCFEBB,
    parameter int NLVL     = clog2(MXCFEB)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_vld,
    input  logic [MXCFEB*MXPATB-1:0] pat,
    input  logic [MXCFEB*MXKEYB-1:0] key,
    input  logic [MXCFEB*MXPATC-1:0] carry,
    input  logic [MXCFEB-1:0]        bsy,
    output logic                     best_vld,
    output logic [MXPATB-1:0]        best_pat,
    output logic [MXKEYBX-1:0]       best_key,
    output logic [MXPATC-1:0]        best_carry,
    output logic [MXCFEBB-1:0]       best_cfeb,
    output logic                     best_bsy
);

    localparam int NLEAF = 1 << NLVL;

    // Heap-ordered tree: node n merges children 2n and 2n+1, the root is
    // node 1 and leaves occupy NLEAF .. 2*NLEAF-1.
    node_t            tree [1:2*NLEAF-1];
    node_t            root;
    logic             root_ok;
    logic [NLVL-1:0]  vld_pipe;

    // Leaves are combinational; busy candidates enter the tree already
    // dead so they can never displace a live one. Padding leaves beyond
    // MXCFEB-1 are permanently dead.
    for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
        if (j < MXCFEB) begin : g_real
            assign tree[NLEAF+j] = '{
                live:  ~bsy[j],
                pat:   pat[j*MXPATB +: MXPATB],
                key:   key[j*MXKEYB +: MXKEYB],
                carry: carry[j*MXPATC +: MXPATC],
                idx:   NODE_IDXB'(j)
            };
        end else begin : g_pad
            assign tree[NLEAF+j] = '0;
        end
    end

    // Level l holds 2^(NLVL-l-1) registered merges; level NLVL-1 is the root.
    for (genvar l = 0; l < NLVL; l++) begin : g_lvl
        for (genvar i = 0; i < (1 << (NLVL - l - 1)); i++) begin : g_node
            localparam int N = (1 << (NLVL - l - 1)) + i;
            cclut_sort_node #(
                .SORT_LSB (SORT_LSB)
            ) u_node (
                .clock (clock),
                .reset (reset),
                .a     (tree[2*N]),
                .b     (tree[2*N+1]),
                .q     (tree[N])
            );
        end
    end

    // Valid strobe travels alongside the tree, one stage per level.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= NLVL'({vld_pipe, in_vld});
        end
    end

    assign root = tree[1];

    // A live root always carries an in-range index; the range test keeps a
    // corrupted upper index bit from ever being reported as a CFEB.
    assign root_ok = root.live && (int'(root.idx) < MXCFEB);

    always_comb begin
        best_vld   = 1'b0;
        best_pat   = '0;
        best_key   = '0;
        best_carry = '0;
        best_cfeb  = '0;
        best_bsy   = 1'b0;
        if (vld_pipe[NLVL-1]) begin
            best_vld = 1'b1;
            if (root_ok) begin
                best_pat   = root.pat;
                best_key   = {root.idx[MXCFEBB-1:0], root.key};
                best_carry = root.carry;
                best_cfeb  = root.idx[MXCFEBB-1:0];
            end else begin
                best_bsy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_best_1ofn_busy_cclut_pipe.sv
// tb/tb_best_1ofn_busy_cclut_pipe.sv - self-checking bench for best_1ofn_busy_cclut_pipe
module tb_best_1ofn_busy_cclut_pipe;

    localparam int ND = 4;
    // Bench configurations: 7 lsb-ignored, 7 full-pattern, 2 and 16 candidates.
    localparam int N_OF   [ND] = '{7, 7, 2, 16};
    localparam int LAT_OF [ND] = '{3, 3, 1, 4};
    localparam int LSB_OF [ND] = '{0, 1, 0, 0};

    typedef struct packed {
        logic        vld;
        logic [5:0]  pat;
        logic [8:0]  key;
        logic [10:0] carry;
        logic [3:0]  cfeb;
        logic        bsy;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic in_vld;

    always #5 clock = ~clock;

    logic [5:0]   pat_a   [16];
    logic [4:0]   key_a   [16];
    logic [10:0]  carry_a [16];
    logic [15:0]  bsy_v;
    logic [95:0]  pat_bus;
    logic [79:0]  key_bus;
    logic [175:0] carry_bus;

    always_comb begin
        pat_bus   = '0;
        key_bus   = '0;
        carry_bus = '0;
        for (int i = 0; i < 16; i++) begin
            pat_bus[i*6 +: 6]    = pat_a[i];
            key_bus[i*5 +: 5]    = key_a[i];
            carry_bus[i*11 +: 11] = carry_a[i];
        end
    end

    logic        v7, b7, v7l, b7l, v2, b2, v16, b16;
    logic [5:0]  p7, p7l, p2, p16;
    logic [7:0]  k7, k7l;
    logic [5:0]  k2;
    logic [8:0]  k16;
    logic [10:0] c7, c7l, c2, c16;
    logic [2:0]  f7, f7l;
    logic [0:0]  f2;
    logic [3:0]  f16;

    best_1ofn_busy_cclut_pipe #(.MXCFEB(7), .SORT_LSB(0)) dut7 (
        .clock(clock), .reset(reset), .in_vld(in_vld),
        .pat(pat_bus[41:0]), .key(key_bus[34:0]), .carry(carry_bus[76:0]), .bsy(bsy_v[6:0]),
        .best_vld(v7), .best_pat(p7), .best_key(k7), .best_carry(c7), .best_cfeb(f7), .best_bsy(b7)
    );

    best_1ofn_busy_cclut_pipe #(.MXCFEB(7), .SORT_LSB(1)) dut7l (
        .clock(clock), .reset(reset), .in_vld(in_vld),
        .pat(pat_bus[41:0]), .key(key_bus[34:0]), .carry(carry_bus[76:0]), .bsy(bsy_v[6:0]),
        .best_vld(v7l), .best_pat(p7l), .best_key(k7l), .best_carry(c7l), .best_cfeb(f7l), .best_bsy(b7l)
    );

    best_1ofn_busy_cclut_pipe #(.MXCFEB(2), .SORT_LSB(0)) dut2 (
        .clock(clock), .reset(reset), .in_vld(in_vld),
        .pat(pat_bus[11:0]), .key(key_bus[9:0]), .carry(carry_bus[21:0]), .bsy(bsy_v[1:0]),
        .best_vld(v2), .best_pat(p2), .best_key(k2), .best_carry(c2), .best_cfeb(f2), .best_bsy(b2)
    );

    best_1ofn_busy_cclut_pipe #(.MXCFEB(16), .SORT_LSB(0)) dut16 (
        .clock(clock), .reset(reset), .in_vld(in_vld),
        .pat(pat_bus), .key(key_bus), .carry(carry_bus), .bsy(bsy_v),
        .best_vld(v16), .best_pat(p16), .best_key(k16), .best_carry(c16), .best_cfeb(f16), .best_bsy(b16)
    );

    exp_t act [ND];
    assign act[0] = {v7,  p7,  9'(k7),  c7,  4'(f7),  b7};
    assign act[1] = {v7l, p7l, 9'(k7l), c7l, 4'(f7l), b7l};
    assign act[2] = {v2,  p2,  9'(k2),  c2,  4'(f2),  b2};
    assign act[3] = {v16, p16, k16,     c16, f16,     b16};

    exp_t hist [ND][0:1023];
    int   s;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    function automatic int quality(input int i, input int full);
        return (full != 0) ? int'(pat_a[i]) : int'(pat_a[i] >> 1);
    endfunction

    // Linear scan over the first n candidates: strictly better quality
    // replaces the current best, so ties keep the lowest live index.
    function automatic exp_t model(input int n, input int full, input logic vld);
        exp_t e;
        int   best;
        e    = '0;
        best = -1;
        for (int i = 0; i < n; i++) begin
            if (!bsy_v[i]) begin
                if (best < 0) best = i;
                else if (quality(i, full) > quality(best, full)) best = i;
            end
        end
        if (!vld) return e;
        e.vld = 1'b1;
        if (best < 0) begin
            e.bsy = 1'b1;
        end else begin
            e.pat   = pat_a[best];
            e.key   = 9'(best * 32 + int'(key_a[best]));
            e.carry = carry_a[best];
            e.cfeb  = 4'(best);
        end
        return e;
    endfunction

    // One clock: apply in_vld with the current candidates, then compare each
    // DUT with the model result from exactly its latency ago.
    task automatic step(input logic v);
        in_vld = v;
        s = s + 1;
        for (int d = 0; d < ND; d++) hist[d][s] = model(N_OF[d], LSB_OF[d], v);
        @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < ND; d++) begin
            exp_t e;
            int   src;
            src = s - LAT_OF[d] + 1;
            e   = (src >= 1) ? hist[d][src] : '0;
            chk_cnt++;
            if (act[d] !== e) $display("FAIL pipe dut%0d step %0d: got %h want %h", d, s, act[d], e);
            else pass_cnt++;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        in_vld = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        s     = 0;
    endtask

    task automatic clear_cands();
        for (int i = 0; i < 16; i++) begin
            pat_a[i]   = '0;
            key_a[i]   = 5'($urandom);
            carry_a[i] = 11'($urandom);
        end
        bsy_v = '0;
    endtask

    task automatic randomize_cands();
        for (int i = 0; i < 16; i++) begin
            pat_a[i]   = 6'($urandom);
            key_a[i]   = 5'($urandom);
            carry_a[i] = 11'($urandom);
        end
        bsy_v = 16'($urandom & $urandom);
        if ($urandom_range(0, 7) == 0) bsy_v = '1;
    endtask

    task automatic test_reset();
        clear_cands();
        do_reset();
        for (int d = 0; d < ND; d++) begin
            chk_cnt++;
            if (act[d] !== '0) $display("FAIL reset_state dut%0d: got %h want 0", d, act[d]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ordered();
        int q [7];
        q = '{1, 2, 3, 4, 5, 6, 2};
        clear_cands();
        for (int i = 0; i < 7; i++) pat_a[i] = 6'((q[i] << 1) | $urandom_range(0, 1));
        repeat (4) step(1'b1);
        chk_cnt++;
        if (f7 !== 3'd5 || k7 !== {3'd5, key_a[5]} || v7 !== 1'b1 || b7 !== 1'b0)
            $display("FAIL ordered_best: cfeb %0d key %h vld %b bsy %b, want cfeb 5 key %h vld 1 bsy 0",
                     f7, k7, v7, b7, {3'd5, key_a[5]});
        else pass_cnt++;
        chk_cnt++;
        if (f2 !== 1'b1) $display("FAIL ordered_n2: cfeb %0d want 1", f2);
        else pass_cnt++;

        bsy_v[5] = 1'b1;
        repeat (4) step(1'b1);
        chk_cnt++;
        if (f7 !== 3'd4 || b7 !== 1'b0) $display("FAIL busy_mask: cfeb %0d bsy %b want cfeb 4 bsy 0", f7, b7);
        else pass_cnt++;

        bsy_v = 16'h007F;
        repeat (4) step(1'b1);
        chk_cnt++;
        if (b7 !== 1'b1 || p7 !== 6'd0 || k7 !== 8'd0 || v7 !== 1'b1)
            $display("FAIL all_busy: bsy %b pat %h key %h vld %b want bsy 1 pat 0 key 0 vld 1", b7, p7, k7, v7);
        else pass_cnt++;
        repeat (3) step(1'b0);
    endtask

    task automatic test_tie();
        clear_cands();
        pat_a[2] = 6'h14;
        pat_a[6] = 6'h14;
        pat_a[3] = 6'h15;
        repeat (4) step(1'b1);
        chk_cnt++;
        if (f7 !== 3'd2) $display("FAIL tie_lsb_ignored: cfeb %0d want 2", f7);
        else pass_cnt++;
        chk_cnt++;
        if (f7l !== 3'd3) $display("FAIL tie_lsb_used: cfeb %0d want 3", f7l);
        else pass_cnt++;

        clear_cands();
        bsy_v = 16'h0001;
        repeat (4) step(1'b1);
        chk_cnt++;
        if (f7 !== 3'd1 || b7 !== 1'b0 || v7 !== 1'b1 || p7 !== 6'd0)
            $display("FAIL zero_pattern: cfeb %0d bsy %b vld %b pat %h want cfeb 1 bsy 0 vld 1 pat 0", f7, b7, v7, p7);
        else pass_cnt++;
        repeat (3) step(1'b0);
    endtask

    task automatic test_latency();
        int         first [ND];
        logic [3:0] hi;
        do_reset();
        clear_cands();
        pat_a[15] = 6'h3F;
        hi = 4'h0;
        for (int d = 0; d < ND; d++) first[d] = -1;
        for (int t = 1; t <= 6; t++) begin
            step(t == 1);
            for (int d = 0; d < ND; d++) if (first[d] < 0 && act[d].vld === 1'b1) first[d] = t;
            if (t == 4) hi = k16[8:5];
        end
        for (int d = 0; d < ND; d++) begin
            chk_cnt++;
            if (first[d] !== LAT_OF[d]) $display("FAIL latency dut%0d: first valid at clock %0d want %0d", d, first[d], LAT_OF[d]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (hi !== 4'hF) $display("FAIL cfeb15_key: key[8:5] %h want f", hi);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            randomize_cands();
            step(1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 6; n++) begin
            randomize_cands();
            step(1'b1);
        end
        repeat (4) step(1'b0);
    endtask

    task automatic test_reset_midstream();
        randomize_cands();
        step(1'b1);
        randomize_cands();
        step(1'b1);
        do_reset();
        for (int d = 0; d < ND; d++) begin
            chk_cnt++;
            if (act[d] !== '0) $display("FAIL midstream_flush dut%0d: got %h want 0", d, act[d]);
            else pass_cnt++;
        end
        repeat (2) step(1'b0);
        randomize_cands();
        bsy_v[0] = 1'b0;
        step(1'b1);
        repeat (4) step(1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        in_vld = 1'b0;
        s      = 0;
        test_reset();
        test_ordered();
        test_tie();
        test_latency();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
